// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the microstep control sequencer: state encoding,
// opcode values, IR field positions and the opcode classes produced by control_decode.
package cpu_ctrl_pkg;

  localparam int OPW = 5;
  localparam int RW  = 4;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [OPW-1:0] OP_ALU_FIRST = 5'b00000;
  localparam logic [OPW-1:0] OP_AND       = 5'b00101;
  localparam logic [OPW-1:0] OP_ROL       = 5'b01001;
  localparam logic [OPW-1:0] OP_ALU_LAST  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL       = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV       = 5'b10000;
  localparam logic [OPW-1:0] OP_NOP       = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT      = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier. Define CONTROL_SEQUENCER_MULDIV_EN to classify
// mul/div as MULDIV; otherwise they fall into ILLEGAL.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (is_alu_op(opcode))
      op_class = CLS_ALU;
    else if (opcode == OP_NOP)
      op_class = CLS_NOP;
    else if (opcode == OP_HALT)
      op_class = CLS_HALT;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
    else if (opcode == OP_MUL || opcode == OP_DIV)
      op_class = CLS_MULDIV;
`endif
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute microstep FSM driving DataPath strobes (Moore outputs).
// CONTROL_SEQUENCER_MULDIV_EN enables the T3-T6 mul/div HI/LO sequence.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  input  logic           Run,
  input  logic [31:0]    IR,
  input  logic           MemRdy,
  output logic           PCout,
  output logic           IncPC,
  output logic           MARin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] AluOp,
  output logic           Halted,
  output logic           Illegal
);

  state_t    state, state_nxt, eoi_nxt;
  op_class_t op_class;
  logic      unused_ir_fields;

  // Register fields are consumed by the datapath's select/encode logic, not here.
  assign unused_ir_fields = ^IR[RA_MSB:0];

  control_decode u_decode (
    .opcode   (IR[OP_MSB:OP_LSB]),
    .op_class (op_class)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign eoi_nxt = Run ? S_T0 : S_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = Run ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = MemRdy ? S_T2 : S_T1;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        case (op_class)
          CLS_ALU, CLS_MULDIV: state_nxt = S_T4;
          CLS_HALT:            state_nxt = S_HALT;
          default:             state_nxt = eoi_nxt;
        endcase
      end
      S_T4:   state_nxt = S_T5;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
      S_T5:   state_nxt = (op_class == CLS_MULDIV) ? S_T6 : eoi_nxt;
      S_T6:   state_nxt = eoi_nxt;
`else
      S_T5:   state_nxt = eoi_nxt;
`endif
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    {PCout, IncPC, MARin, Read, MDRin, MDRout, IRin} = '0;
    {Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin} = '0;
    {Gra, Grb, Grc, Rin, Rout} = '0;
    AluOp   = '0;
    Halted  = 1'b0;
    Illegal = 1'b0;
    case (state)
      S_T0: {PCout, MARin, IncPC} = '1;
      S_T1: {Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        case (op_class)
          CLS_ALU:     {Grb, Rout, Yin} = '1;
          CLS_MULDIV:  {Gra, Rout, Yin} = '1;
          CLS_ILLEGAL: Illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        AluOp = IR[OP_MSB:OP_LSB];
        if (op_class == CLS_MULDIV) begin
          {Grb, Rout, ZLowIn} = '1;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
          ZHighIn = 1'b1;
`endif
        end else begin
          {Grc, Rout, ZLowIn} = '1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
          LOin = 1'b1;
`endif
        end else begin
          {Gra, Rin} = '1;
        end
      end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
      S_T6: {ZHighout, HIin} = '1;
`endif
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expectations follow the
// CONTROL_SEQUENCER_MULDIV_EN setting of the build.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, Run, MemRdy;
  logic [31:0] IR;
  logic PCout, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, Halted, Illegal;
  logic [4:0] AluOp;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemRdy(MemRdy),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .AluOp(AluOp), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Observation vector: 21 strobe bits followed by the 5-bit AluOp.
  localparam logic [25:0] B_PCOUT = 26'd1 << 25, B_INCPC = 26'd1 << 24, B_MARIN = 26'd1 << 23;
  localparam logic [25:0] B_READ  = 26'd1 << 22, B_MDRIN = 26'd1 << 21, B_MDROUT = 26'd1 << 20;
  localparam logic [25:0] B_IRIN  = 26'd1 << 19, B_YIN = 26'd1 << 18, B_ZLOWIN = 26'd1 << 17;
  localparam logic [25:0] B_ZHIGHIN = 26'd1 << 16, B_ZLOWOUT = 26'd1 << 15, B_ZHIGHOUT = 26'd1 << 14;
  localparam logic [25:0] B_HIIN = 26'd1 << 13, B_LOIN = 26'd1 << 12, B_GRA = 26'd1 << 11;
  localparam logic [25:0] B_GRB = 26'd1 << 10, B_GRC = 26'd1 << 9, B_RIN = 26'd1 << 8;
  localparam logic [25:0] B_ROUT = 26'd1 << 7, B_HALTED = 26'd1 << 6, B_ILLEGAL = 26'd1 << 5;

  localparam logic [25:0] V_NONE = 26'd0;
  localparam logic [25:0] V_T0   = B_PCOUT | B_INCPC | B_MARIN;
  localparam logic [25:0] V_T1   = B_READ | B_MDRIN;
  localparam logic [25:0] V_T2   = B_MDROUT | B_IRIN;
  localparam logic [25:0] V_T3A  = B_GRB | B_ROUT | B_YIN;
  localparam logic [25:0] V_T4A  = B_GRC | B_ROUT | B_ZLOWIN;
  localparam logic [25:0] V_T5A  = B_ZLOWOUT | B_GRA | B_RIN;
  localparam logic [25:0] V_T3M  = B_GRA | B_ROUT | B_YIN;
  localparam logic [25:0] V_T4M  = B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN;
  localparam logic [25:0] V_T5M  = B_ZLOWOUT | B_LOIN;
  localparam logic [25:0] V_T6M  = B_ZHIGHOUT | B_HIIN;
  localparam logic [25:0] V_ILL  = B_ILLEGAL;
  localparam logic [25:0] V_HALT = B_HALTED;

  function automatic logic [25:0] obs();
    return {PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
            Zlowout, ZHighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, Halted, Illegal, AluOp};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] got;
    Clear = 1'b1; Run = 1'b1; MemRdy = 1'b1; IR = 32'h0;
    #1;
    repeat (3) tick();
    got = obs();
    checks++;
    if (got !== V_NONE) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, V_NONE);
    end
    Clear = 1'b0;
    tick();
    got = obs();
    checks++;
    if (got !== V_T0) begin
      errors++; $display("FAIL reset_first_t0 got=%h exp=%h", got, V_T0);
    end
  endtask

  task automatic test_alu_and();
    logic [25:0] seq [7];
    logic [25:0] got;
    seq = '{V_T0, V_T1, V_T2, V_T3A, V_T4A | 26'(5'b00101), V_T5A, V_T0};
    IR = 32'h28918000; MemRdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      got = obs();
      checks++;
      if (got !== seq[i]) begin
        errors++; $display("FAIL alu_and step %0d got=%h exp=%h", i, got, seq[i]);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_rol_wait_clear();
    logic [25:0] seq [10];
    logic [25:0] got;
    seq = '{V_T0, V_T1, V_T1, V_T1, V_T1, V_T2, V_T3A, V_T4A | 26'(5'b01001), V_T5A, V_T0};
    IR = {5'b01001, 4'd1, 4'd2, 4'd3, 15'd0}; MemRdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got = obs();
      checks++;
      if (got !== seq[i]) begin
        errors++; $display("FAIL rol_wait step %0d got=%h exp=%h", i, got, seq[i]);
      end
      if (i == 4) MemRdy = 1'b1;
      if (i < 9) tick();
    end
    // Second run: Clear arrives asynchronously while waiting on memory.
    MemRdy = 1'b0;
    tick();
    got = obs();
    checks++;
    if (got !== V_T1) begin
      errors++; $display("FAIL clear_pre_t1 got=%h exp=%h", got, V_T1);
    end
    Clear = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== V_NONE) begin
      errors++; $display("FAIL clear_async got=%h exp=%h", got, V_NONE);
    end
    #1 Clear = 1'b0; MemRdy = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== V_T0) begin
      errors++; $display("FAIL clear_restart got=%h exp=%h", got, V_T0);
    end
  endtask

  task automatic test_muldiv();
    logic [25:0] got;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
    localparam int N = 8;
    logic [25:0] seq [N];
    seq = '{V_T0, V_T1, V_T2, V_T3M, V_T4M | 26'(5'b01111), V_T5M, V_T6M, V_T0};
`else
    localparam int N = 5;
    logic [25:0] seq [N];
    seq = '{V_T0, V_T1, V_T2, V_ILL, V_T0};
`endif
    IR = {5'b01111, 4'd4, 4'd5, 4'd0, 15'd0}; MemRdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      got = obs();
      checks++;
      if (got !== seq[i]) begin
        errors++; $display("FAIL muldiv step %0d got=%h exp=%h", i, got, seq[i]);
      end
      if (i < N - 1) tick();
    end
  endtask

  task automatic test_nop_halt();
    logic [25:0] seq [12];
    logic [25:0] got;
    seq = '{V_T0, V_T1, V_T2, V_NONE, V_T0, V_T1, V_T2, V_NONE, V_HALT, V_HALT, V_HALT, V_HALT};
    IR = {5'b11010, 27'd0}; Run = 1'b1; MemRdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      got = obs();
      checks++;
      if (got !== seq[i]) begin
        errors++; $display("FAIL nop_halt step %0d got=%h exp=%h", i, got, seq[i]);
      end
      if (i == 4) IR = {5'b11011, 27'd0};
      if (i < 11) tick();
    end
    Clear = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== V_NONE) begin
      errors++; $display("FAIL halt_clear got=%h exp=%h", got, V_NONE);
    end
    Run = 1'b0;
    #1 Clear = 1'b0;
    repeat (2) begin
      tick();
      got = obs();
      checks++;
      if (got !== V_NONE) begin
        errors++; $display("FAIL idle_after_halt got=%h exp=%h", got, V_NONE);
      end
    end
  endtask

  task automatic test_illegal_run_low();
    logic [25:0] seq [11];
    logic [25:0] got;
    seq = '{V_T0, V_T1, V_T2, V_ILL, V_T0, V_T1, V_T2, V_ILL, V_NONE, V_NONE, V_NONE};
    IR = 32'hF8000000; Run = 1'b1; MemRdy = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      got = obs();
      checks++;
      if (got !== seq[i]) begin
        errors++; $display("FAIL illegal_runlow step %0d got=%h exp=%h", i, got, seq[i]);
      end
      if (i == 4) IR = 32'h58000000;
      if (i == 5) Run = 1'b0;
      if (i < 10) tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_and();
    test_rol_wait_clear();
    test_muldiv();
    test_nop_halt();
    test_illegal_run_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
